// File: rtl/polyphase_interpolator.sv
// Runtime-selectable 1..L_MAX upsampler built on an L_MAX-phase polyphase FIR.
// One shared input delay line; one phase is computed per output sample, with a combinational bypass.
module polyphase_interpolator #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int L_MAX       = 4,
    parameter int TAPS        = 4,
    parameter logic signed [L_MAX*TAPS*COEFF_WIDTH-1:0] COEFFS = '0,
    localparam int OUTPUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS) + 1,
    localparam int FW           = $clog2(L_MAX + 1)
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           bypass,
    input  logic [FW-1:0]                  factor_in,
    input  logic signed [DATA_WIDTH-1:0]   src_data_in,
    input  logic                           src_valid_in,
    output logic                           src_ready_out,
    output logic signed [OUTPUT_WIDTH-1:0] dst_data_out,
    output logic                           dst_valid_out,
    input  logic                           dst_ready_in,
    output logic                           busy_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0]   x_p0 [TAPS];
    logic signed [OUTPUT_WIDTH-1:0] acc_p1;
    logic signed [OUTPUT_WIDTH-1:0] sum_p0;
    logic signed [OUTPUT_WIDTH-1:0] bypass_data;
    logic [FW-1:0]                  phase;
    logic [FW-1:0]                  factor_q;
    logic                           accept;
    logic                           last_phase;

    // A factor of 0 still produces one output; anything above L_MAX is capped.
    function automatic logic [FW-1:0] clamp_factor(input logic [FW-1:0] f);
        if (f == '0) begin
            return FW'(1);
        end
        if (int'(f) > L_MAX) begin
            return FW'(L_MAX);
        end
        return f;
    endfunction

    function automatic logic signed [COEFF_WIDTH-1:0] coef(input int p, input int k);
        return COEFFS[(p*TAPS + k)*COEFF_WIDTH +: COEFF_WIDTH];
    endfunction

    assign accept     = !bypass && (state_q == IDLE) && src_valid_in;
    assign last_phase = (phase == factor_q - FW'(1));

    // Operands are widened before multiplying so every partial product and the sum stay exact.
    always_comb begin
        sum_p0 = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_p0 = sum_p0 + OUTPUT_WIDTH'(coef(int'(phase), k)) * OUTPUT_WIDTH'(x_p0[k]);
        end
    end

    assign bypass_data = OUTPUT_WIDTH'(src_data_in) <<< (COEFF_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: state_d = OUT;
            OUT: begin
                if (dst_ready_in) begin
                    state_d = last_phase ? IDLE : CALC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input stage: delay line and per-sample factor; accumulator holds the phase result for OUT.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_p0[k] <= '0;
            end
            acc_p1   <= '0;
            phase    <= '0;
            factor_q <= '0;
        end else begin
            if (accept) begin
                x_p0[0] <= src_data_in;
                for (int k = 1; k < TAPS; k++) begin
                    x_p0[k] <= x_p0[k-1];
                end
                factor_q <= clamp_factor(factor_in);
                phase    <= '0;
            end
            if (state_q == CALC) begin
                acc_p1 <= sum_p0;
            end
            if ((state_q == OUT) && dst_ready_in && !last_phase) begin
                phase <= phase + FW'(1);
            end
        end
    end

    assign src_ready_out = bypass ? dst_ready_in : (state_q == IDLE);
    assign dst_valid_out = bypass ? src_valid_in : (state_q == OUT);
    assign dst_data_out  = bypass ? bypass_data : acc_p1;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_polyphase_interpolator.sv
// Directed and random bench for polyphase_interpolator with a queue-based scoreboard.
// Two instances share stimulus: ramp coefficients and all-minimum coefficients.
`timescale 1ns/1ps
module tb_polyphase_interpolator;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int LM  = 4;
    localparam int NT  = 4;
    localparam int OW  = DW + CW + $clog2(NT) + 1;
    localparam int FWL = $clog2(LM + 1);

    function automatic logic [LM*NT*CW-1:0] ramp_coeffs();
        logic [LM*NT*CW-1:0] v;
        v = '0;
        for (int i = 0; i < LM*NT; i++) begin
            v[i*CW +: CW] = CW'(i + 1);
        end
        return v;
    endfunction

    localparam logic [LM*NT*CW-1:0] RAMP = ramp_coeffs();
    localparam logic [LM*NT*CW-1:0] NEG  = {(LM*NT){16'h8000}};

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic                  bypass;
    logic [FWL-1:0]        factor_in;
    logic signed [DW-1:0]  src_data_in;
    logic                  src_valid_in;
    logic                  dst_ready_in;
    logic signed [OW-1:0]  d1, d2;
    logic                  v1, v2, r1, r2, b1, b2;

    always #5 clk = ~clk;

    polyphase_interpolator #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .L_MAX(LM), .TAPS(NT), .COEFFS(RAMP)
    ) dut (
        .clk(clk), .arst_n(arst_n), .bypass(bypass), .factor_in(factor_in),
        .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(r1),
        .dst_data_out(d1), .dst_valid_out(v1), .dst_ready_in(dst_ready_in), .busy_out(b1)
    );

    polyphase_interpolator #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .L_MAX(LM), .TAPS(NT), .COEFFS(NEG)
    ) dut_neg (
        .clk(clk), .arst_n(arst_n), .bypass(bypass), .factor_in(factor_in),
        .src_data_in(src_data_in), .src_valid_in(src_valid_in), .src_ready_out(r2),
        .dst_data_out(d2), .dst_valid_out(v2), .dst_ready_in(dst_ready_in), .busy_out(b2)
    );

    logic signed [63:0] q1[$];
    logic signed [63:0] q2[$];
    longint tbx [NT];
    int total = 0;
    int bad = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_coef(bit neg, int p, int k);
        return neg ? -64'sd32768 : longint'(p*4 + k + 1);
    endfunction

    task automatic push_model(input logic signed [DW-1:0] d, input int f);
        int fq;
        longint s1, s2;
        fq = (f == 0) ? 1 : ((f > LM) ? LM : f);
        for (int k = NT-1; k > 0; k--) tbx[k] = tbx[k-1];
        tbx[0] = longint'(d);
        for (int p = 0; p < fq; p++) begin
            s1 = 0;
            s2 = 0;
            for (int k = 0; k < NT; k++) begin
                s1 += model_coef(1'b0, p, k) * tbx[k];
                s2 += model_coef(1'b1, p, k) * tbx[k];
            end
            q1.push_back(s1);
            q2.push_back(s2);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [DW-1:0] d, input int f);
        int n;
        src_data_in  = d;
        factor_in    = FWL'(f);
        src_valid_in = 1'b1;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (r1) break;
            step();
            if (rand_ready) dst_ready_in = 1'($urandom_range(0, 1));
            n++;
        end
        total++;
        assert (n < 500) else begin
            bad++;
            $error("FAIL send_wait observed=%0d cycles expected=<500", n);
        end
        step();
        src_valid_in = 1'b0;
        if (n < 500) push_model(d, f);
        if (rand_ready) begin
            dst_ready_in = 1'($urandom_range(0, 1));
            factor_in    = FWL'($urandom_range(0, 7));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (!b1 && q1.size() == 0) break;
            step();
            if (rand_ready) dst_ready_in = 1'($urandom_range(0, 1));
            n++;
        end
        total++;
        assert (n < 500) else begin
            bad++;
            $error("FAIL drain_wait observed=%0d cycles expected=<500", n);
        end
        step();
    endtask

    always @(negedge clk) begin
        if (arst_n && !bypass && dst_ready_in) begin
            if (v1) begin
                total++;
                assert (q1.size() > 0) else begin
                    bad++;
                    $error("FAIL out1_unexpected observed=%0d expected=queued", d1);
                end
                if (q1.size() > 0) check("out1", d1, q1.pop_front());
            end
            if (v2) begin
                total++;
                assert (q2.size() > 0) else begin
                    bad++;
                    $error("FAIL out2_unexpected observed=%0d expected=queued", d2);
                end
                if (q2.size() > 0) check("out2", d2, q2.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] r;
        arst_n = 1'b0; bypass = 1'b0; factor_in = FWL'(4);
        src_data_in = '0; src_valid_in = 1'b0; dst_ready_in = 1'b1;
        for (int k = 0; k < NT; k++) tbx[k] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", r1, 1);
        check("rst_valid", v1, 0);
        check("rst_busy", b1, 0);
        check("rst_data", d1, 0);
        check("rst_busy_neg", b2, 0);
        check("rst_ready_neg", r2, 1);
        step();
        arst_n = 1'b1;

        // Impulse, factor 4, with latency and phase spacing
        send(1, 4);
        @(negedge clk);
        check("lat_calc_valid", v1, 0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("phase_spacing", v1, (i % 2 == 0) ? 1 : 0);
            check("busy_during", b1, 1);
        end
        step();
        @(negedge clk);
        check("idle_after", b1, 0);
        step();
        for (int i = 0; i < 3; i++) send(0, 4);
        drain();

        // Factor selection: 2, 0 (-> 1) and 7 (-> 4)
        send(1, 2);
        for (int i = 0; i < 3; i++) send(0, 2);
        drain();
        send(1, 0);
        for (int i = 0; i < 3; i++) send(0, 0);
        drain();
        send(1, 7);
        for (int i = 0; i < 3; i++) send(0, 7);
        drain();

        // Backpressure on phase 1 (value 5)
        for (int i = 0; i < 3; i++) send(0, 4);
        drain();
        send(1, 4);
        step();
        step();
        dst_ready_in = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_data", d1, 5);
            check("stall_valid", v1, 1);
            check("stall_src_ready", r1, 0);
            step();
        end
        dst_ready_in = 1'b1;
        drain();

        // Bypass
        bypass = 1'b1; src_data_in = 100; src_valid_in = 1'b1; dst_ready_in = 1'b1;
        #1;
        check("byp_data_100", d1, 3276800);
        check("byp_valid", v1, 1);
        check("byp_busy", b1, 0);
        check("byp_ready", r1, 1);
        src_data_in = -1;
        #1;
        check("byp_data_m1", d1, -32768);
        dst_ready_in = 1'b0;
        #1;
        check("byp_ready_low", r1, 0);
        src_valid_in = 1'b0;
        #1;
        check("byp_valid_low", v1, 0);
        dst_ready_in = 1'b1; src_valid_in = 1'b1;
        step();
        step();
        check("byp_hold_idle", b1, 0);
        src_valid_in = 1'b0; bypass = 1'b0;
        step();
        send(0, 4);
        drain();

        // Reset while an output is pending
        send(1, 4);
        dst_ready_in = 1'b0;
        step();
        check("pre_rst_valid", v1, 1);
        arst_n = 1'b0;
        q1.delete();
        q2.delete();
        for (int k = 0; k < NT; k++) tbx[k] = 0;
        step();
        arst_n = 1'b1;
        dst_ready_in = 1'b1;
        @(negedge clk);
        check("post_rst_valid", v1, 0);
        check("post_rst_busy", b1, 0);
        check("post_rst_data", d1, 0);
        step();
        send(1, 4);
        drain();

        // Signed extremes
        for (int i = 0; i < 3; i++) send(-32768, 4);
        drain();
        send(-32768, 4);
        @(negedge clk);
        @(negedge clk);
        check("extreme_valid", v2, 1);
        check("extreme_data", d2, 64'sd4294967296);
        step();
        drain();

        // Random samples, factors and downstream ready
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            send(r[15:0], int'($urandom_range(0, 7)));
        end
        drain();
        rand_ready = 1'b0;
        dst_ready_in = 1'b1;
        drain();
        check("leftover_q1", q1.size(), 0);
        check("leftover_q2", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
